// File: rtl/uart_pkg.sv
// Shared register offsets, store codes, STATUS bit positions and FSM state types
// for the memory-mapped UART responder.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_BYTE = 2'b11;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_RX_FERR  = 6;
    localparam int ST_TX_OVF   = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO; head is combinational, push/pop take effect on the clock edge.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB separates the full case from the empty case.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TXDATA/RXDATA/STATUS window on the data bus, TX and RX byte FIFOs.
// Register reads are combinational; full TX FIFO drops stores (tx_ovf), full RX FIFO drops frames (rx_ovr).
module uart_mmio_periph
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 10417,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mem_write,
    input  logic        read_en,
    output logic        sel,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  offset;
    logic        wr_en;
    logic        wr_tx;
    logic        sticky_clr;
    logic [7:0]  status;

    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_head;
    tx_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shreg;
    logic        tx_busy;

    logic        rx_full, rx_empty, rx_pop, rx_push;
    logic [7:0]  rx_head;
    rx_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shreg;
    logic        rx_meta, rx_s, rx_hold;
    logic        ferr_set;

    logic        tx_ovf, rx_ovr, rx_ferr;
    logic        unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:2];
    assign wr_en      = sel && (mem_write inside {MW_WORD, MW_HALF, MW_BYTE});
    assign wr_tx      = wr_en && (offset == OFF_TXDATA);
    assign sticky_clr = wr_en && (offset == OFF_STATUS);
    assign rx_pop     = sel && read_en && (offset == OFF_RXDATA) && !rx_empty;
    assign tx_pop     = (tx_state == TX_IDLE) && !tx_empty;
    assign tx_busy    = (tx_state != TX_IDLE);

    assign rx_push  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s;
    assign ferr_set = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_s;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (tx_head)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shreg),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_head)
    );

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_FERR]  = rx_ferr;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                OFF_TXDATA: rdata = '0;
                OFF_RXDATA: rdata = rx_empty ? 32'hFFFF_FFFF : {24'b0, rx_head};
                OFF_STATUS: rdata = {24'b0, status};
                OFF_RSVD:   rdata = '0;
                default:    rdata = '0;
            endcase
        end
    end

    // A set in the same cycle as a STATUS write wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf  <= 1'b0;
            rx_ovr  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            tx_ovf  <= (wr_tx && tx_full && !tx_pop) || (tx_ovf && !sticky_clr);
            rx_ovr  <= (rx_push && rx_full && !rx_pop) || (rx_ovr && !sticky_clr);
            rx_ferr <= ferr_set || (rx_ferr && !sticky_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx     <= 1'b1;
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_shreg <= tx_head;
                        tx       <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shreg[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shreg <= tx_shreg >> 1;
                            tx       <= tx_shreg[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    tx <= 1'b1;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // After a framing error the line must return high before a new start bit is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_hold  <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_hold) begin
                        if (rx_s) rx_hold <= 1'b0;
                    end else if (!rx_s) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s, rx_shreg[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (!rx_s) rx_hold <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x400.
module tb_uart_mmio_periph;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mem_write;
    logic        read_en;
    logic        sel;
    logic [31:0] rdata;
    logic        rx;
    logic        tx;

    int checks = 0;
    int errors = 0;
    logic [8:0] txq[$];

    uart_mmio_periph #(
        .BASE_ADDR    (32'h0000_0400),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .read_en   (read_en),
        .sel       (sel),
        .rdata     (rdata),
        .rx        (rx),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mw;
        logic        rd;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        read_en = 1'b1;
        @(negedge clk);
        check(name, rdata, exp);
        @(posedge clk);
        #1 read_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
        addr = a;
        wdata = d;
        mem_write = mw;
        @(posedge clk);
        #1 mem_write = 2'b00;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rx = b[k];
            repeat (4) @(posedge clk);
        end
        #1 rx = stop;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    // Serial receiver model for tx: samples mid-bit and queues {stop, byte}.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (4) @(negedge clk);
                    b[k] = tx;
                end
                repeat (4) @(negedge clk);
                txq.push_back({tx, b});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[13];
        logic [7:0] txb;
        logic [7:0] rxexp[4];
        bit done;

        vecs[0]  = '{32'h0000_0408, 32'h0,         2'b00, 1'b1, 1'b1, 32'h0000_0006};
        vecs[1]  = '{32'h0000_0404, 32'h0,         2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h0000_0404, 32'h0,         2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[3]  = '{32'h0000_040C, 32'h0,         2'b00, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0410, 32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5]  = '{32'h0000_03FC, 32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6]  = '{32'h8000_0408, 32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7]  = '{32'h0000_040C, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b1, 32'h0000_0000};
        vecs[8]  = '{32'h0000_0404, 32'h0000_00AB, 2'b11, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[9]  = '{32'h0000_0408, 32'h0,         2'b00, 1'b1, 1'b1, 32'h0000_0006};
        vecs[10] = '{32'h0000_0408, 32'h0000_00FF, 2'b10, 1'b0, 1'b1, 32'h0000_0006};
        vecs[11] = '{32'h0000_0408, 32'h0,         2'b00, 1'b1, 1'b1, 32'h0000_0006};
        vecs[12] = '{32'h0000_0000, 32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_0000};

        reset = 1'b1;
        addr = 32'h0;
        wdata = 32'h0;
        mem_write = 2'b00;
        read_en = 1'b0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'b0, tx}, 32'h1);

        // Register-access vectors
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            addr = vecs[i].addr;
            wdata = vecs[i].wdata;
            mem_write = vecs[i].mw;
            read_en = vecs[i].rd;
            @(negedge clk);
            check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        @(posedge clk);
        #1;
        mem_write = 2'b00;
        read_en = 1'b0;

        // Single byte store: cycle-accurate frame shape and busy flag
        txb = 8'h55;
        do_write(32'h400, 32'h1234_5655, 2'b11);
        addr = 32'h408;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            logic exp_tx;
            @(negedge clk);
            if (i < 4)       exp_tx = 1'b0;
            else if (i < 36) exp_tx = txb[(i - 4) / 4];
            else             exp_tx = 1'b1;
            check($sformatf("tx55_bit_c%0d", i), {31'b0, tx}, {31'b0, exp_tx});
            check($sformatf("tx55_busy_c%0d", i), {31'b0, rdata[4]}, 32'h1);
        end
        @(negedge clk);
        check("tx55_idle_status", rdata, 32'h0000_0006);
        check("tx55_idle_tx", {31'b0, tx}, 32'h1);
        repeat (5) @(posedge clk);
        #1;

        // TX overflow: six stores into a 4-deep FIFO with one byte already shifting out
        txq.delete();
        for (int k = 1; k <= 6; k++) begin
            addr = 32'h400;
            wdata = k;
            mem_write = 2'b01;
            @(posedge clk);
            #1;
        end
        mem_write = 2'b00;
        addr = 32'h408;
        @(negedge clk);
        check("ovf_status_set", rdata, 32'h0000_0095);
        @(posedge clk);
        #1 do_write(32'h408, 32'h0, 2'b01);
        @(negedge clk);
        check("ovf_status_clr", rdata, 32'h0000_0015);
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            if (txq.size() >= 5) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL ovf_frames_timeout got %0d frames required 5", txq.size());
        end
        repeat (60) @(posedge clk);
        #1;
        check("ovf_frame_count", txq.size(), 32'd5);
        for (int k = 0; k < 5 && k < txq.size(); k++)
            check($sformatf("ovf_frame%0d", k), {23'b0, txq[k]}, {23'b0, 1'b1, 8'(k + 1)});
        do_read(32'h408, 32'h0000_0006, "ovf_drained_status");

        // RX single frame then pop
        send_frame(8'hA3, 1'b1);
        repeat (3) @(posedge clk);
        #1 addr = 32'h408;
        @(negedge clk);
        check("rxA3_status", rdata, 32'h0000_0002);
        @(posedge clk);
        #1 do_read(32'h404, 32'h0000_00A3, "rxA3_data");
        do_read(32'h404, 32'hFFFF_FFFF, "rxA3_empty_after_pop");

        // Start-bit glitch, then framing error
        @(posedge clk);
        #1 rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1 do_read(32'h408, 32'h0000_0006, "glitch_status");
        send_frame(8'h5A, 1'b0);
        repeat (6) @(posedge clk);
        #1 do_read(32'h408, 32'h0000_0046, "ferr_status");
        do_write(32'h408, 32'h0, 2'b11);
        do_read(32'h408, 32'h0000_0006, "ferr_cleared");

        // Fill RX FIFO, then a fifth frame lands in the same cycle as a pop
        rxexp = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) send_frame(rxexp[k], 1'b1);
        repeat (3) @(posedge clk);
        #1 do_read(32'h408, 32'h0000_000A, "rxfull_status");
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (41) @(posedge clk);
                #1;
                addr = 32'h404;
                read_en = 1'b1;
                @(negedge clk);
                check("rxfull_pop_head", rdata, 32'h0000_0011);
                @(posedge clk);
                #1 read_en = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1 do_read(32'h408, 32'h0000_000A, "rxfull_no_ovr");
        do_read(32'h404, 32'h0000_0022, "rxfull_q0");
        do_read(32'h404, 32'h0000_0033, "rxfull_q1");
        do_read(32'h404, 32'h0000_0044, "rxfull_q2");
        do_read(32'h404, 32'h0000_0055, "rxfull_q3");
        do_read(32'h404, 32'hFFFF_FFFF, "rxfull_drained");

        // Reset in the middle of a frame
        do_write(32'h400, 32'h0, 2'b11);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (tx === 1'b0) done = 1'b1;
        end
        check("midreset_saw_start", {31'b0, done}, 32'h1);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        addr = 32'h408;
        @(posedge clk);
        @(negedge clk);
        check("midreset_tx_high", {31'b0, tx}, 32'h1);
        check("midreset_status", rdata, 32'h0000_0006);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_periph.md
Name: uart_mmio_periph

Overview:
- Memory-mapped UART responder on the core's data-memory bus; the target end of the load/store path driven by the instruction decoder's MemWrite/READMODE outputs.
- Decodes store size codes and read strobes, buffers bytes in TX/RX FIFOs, serialises/deserialises 8N1 frames on tx/rx.
- Load-size extraction (READMODE) stays in the datapath; this block always returns a full 32-bit word.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 16-byte register window.
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); minimum 4.
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs; power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from ALU result.
- wdata  in  32  store data (RF second operand).
- mem_write  in  2  store code: 00 none, 01 word, 10 half, 11 byte.
- read_en  in  1  load strobe, high for the load instruction's cycle.
- sel  out  1  combinational; high when addr[31:4]==BASE_ADDR[31:4].
- rdata  out  32  combinational read data for addr.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output, idle high.

Behaviour:
- Register map (offset addr[3:2]): 0 TXDATA (W), 1 RXDATA (R, pops), 2 STATUS (R; any write clears sticky bits), 3 reserved (reads 0, writes ignored).
- Writes: any non-zero mem_write with sel and offset 0 pushes wdata[7:0]. The size code only qualifies the write; byte, half and word behave identically.
  - TX FIFO full: the byte is dropped and tx_ovf is set (sticky).
- RXDATA read: rdata={24'b0,head}. The pop occurs at the clock edge where sel & read_en & offset==1.
  - RX FIFO empty: rdata=32'hFFFF_FFFF and no pop.
- STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 tx_busy, bit5 rx_ovr, bit6 rx_ferr, bit7 tx_ovf; all other bits 0.
- rdata is 0 when sel=0.
- Reset: tx=1, both FIFOs empty, all FSMs IDLE, sticky bits 0, counters 0. STATUS therefore reads 32'h0000_0006.
  - Reset mid-frame aborts the frame immediately; tx returns high on the next cycle.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE with FIFO non-empty: pop the byte into the shift register and enter START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - After STOP, go to IDLE. If the FIFO is non-empty, START of the next byte begins on the following cycle (one idle-high cycle between frames).
  - tx_busy=1 whenever state!=IDLE.
- RX path: rx passes through a 2-flop synchroniser to give rx_s.
  - IDLE: rx_s==0 enters START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample rx_s. If rx_s==1 (glitch), return to IDLE; otherwise enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample==1: push the byte. If the RX FIFO is full, drop it and set rx_ovr.
    - Sample==0: discard the byte, set rx_ferr, and wait in IDLE for rx_s==1 before re-arming.
- FIFO push and pop in the same cycle:
  - Both succeed when the FIFO is non-empty.
  - When empty, the pop sees empty (push only).
  - When full, the pop frees a slot and the push succeeds (no overflow).
- Pointers are log2(FIFO_DEPTH)+1 bits wide. The extra MSB distinguishes full from empty, and pointers wrap modulo 2*FIFO_DEPTH.
- Sticky-bit clear (STATUS write) has priority below a same-cycle set: the set wins.

Decomposition:
- Package uart_pkg:
  - register offsets;
  - mem_write codes (MW_NONE, MW_WORD, MW_HALF, MW_BYTE);
  - STATUS bit indices;
  - tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_STOP};
  - rx_state_t {RX_IDLE, RX_START, RX_DATA, RX_STOP}.
- One sub-module, sync_fifo (8-bit wide, FIFO_DEPTH parameter, push/pop/full/empty/head), instantiated twice for TX and RX.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h400):
- Reset, then read 0x408 -> rdata=32'h0000_0006; tx=1; read 0x404 -> 32'hFFFF_FFFF.
- Byte store 32'h1234_5655 to 0x400 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; tx_busy=1 throughout.
- 6 back-to-back word stores 0x01..0x06 -> 5 bytes transmitted (1 in shift register plus 4 queued); STATUS bit7=1; write 0x408 -> bit7 clears.
- Drive an rx frame for 0xA3 -> STATUS bit2 goes 0 after the stop bit; load 0x404 -> 32'h0000_00A3; next load -> 32'hFFFF_FFFF.
- rx low pulse of 1 cycle -> nothing received, bit6=0. Frame 0x5A with stop bit 0 -> bit6=1, RX FIFO stays empty.
- RX FIFO full (4 frames) plus a 5th frame arriving in the same cycle as a 0x404 load -> no overrun; 4 entries remain, head advances by one.
